// File: rtl/reg_readback_pkg.sv
// Shared definitions for the register-bank debug readback unit:
// state encoding, frame length derivation and the parity helper.
package reg_readback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Widest address+data payload the parity helper can cover.
  localparam int PAR_MAX_W = 64;

  function automatic int frame_bits(input int addr_w, input int data_w);
    return addr_w + data_w + 3;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/reg_readback_bit_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit period. clr holds the count at zero.
module reg_readback_bit_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: cleared by clr, wraps after the last cycle of a bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/reg_readback.sv
// Debug readback unit: snapshots one register of the bank on request and
// shifts it out as a framed serial word (start, addr, data, parity, stop).
module reg_readback
  import reg_readback_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       done,
  output logic                       addr_err
);

  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int IDX_MAX    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int IDX_W      = $clog2(IDX_MAX) + 1;
  localparam int AW1        = ADDR_W + 1;
  localparam logic [ADDR_W:0] NUM_REGS_L = AW1'(NUM_REGS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    tx_q, tx_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    addr_err_q, addr_err_d;

  logic [DATA_W-1:0]       sel_data_s;
  logic [FRAME_BITS-1:0]   frame_s;
  logic [FRAME_BITS-1:0]   shift_s;
  logic                    addr_ok_s;
  logic                    idle_s;
  logic                    tick_s;

  assign idle_s = (state_q == ST_IDLE);

  reg_readback_bit_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (idle_s),
    .tick  (tick_s)
  );

  // Register mux and the complete frame image, LSB transmitted first.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sel_data_s = (req_addr == ADDR_W'(i)) ? reg_bank[i*DATA_W +: DATA_W] : sel_data_s;
    end
    addr_ok_s = ({1'b0, req_addr} < NUM_REGS_L);
    frame_s   = {1'b1,
                 even_parity(PAR_MAX_W'({sel_data_s, req_addr})),
                 sel_data_s, req_addr, 1'b0};
    shift_s   = {1'b1, shreg_q[FRAME_BITS-1:1]};
  end

  // Sequencing FSM; outputs are computed from the next state and registered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          if (addr_ok_s) begin
            state_d = ST_START;
            shreg_d = frame_s;
          end else begin
            addr_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d = ST_ADDR;
          shreg_d = shift_s;
        end else begin
          state_d = ST_START;
        end
      end
      ST_ADDR: begin
        if (tick_s) begin
          shreg_d = shift_s;
          if (idx_q == IDX_W'(ADDR_W - 1)) begin
            state_d = ST_DATA;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d   = idx_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shreg_d = shift_s;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            idx_d   = idx_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
          shreg_d = shift_s;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
    tx_d    = (state_d == ST_IDLE) ? 1'b1 : shreg_d[0];
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      shreg_q    <= {FRAME_BITS{1'b1}};
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign req_ready = ready_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: table-driven frames plus corner-case
// sequences, checked against a bit-list frame model.
module tb_reg_readback;

  localparam int NR    = 12;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int CPB   = 4;
  localparam int FB    = AW + DW + 3;
  localparam int FCYC  = FB * CPB;

  logic              clk;
  logic              rst_n;
  logic [NR*DW-1:0]  reg_bank;
  logic              req_valid;
  logic [AW-1:0]     req_addr;
  logic              req_ready;
  logic              tx;
  logic              busy;
  logic              done;
  logic              addr_err;

  int n_checks;
  int n_errors;
  int done_cnt;

  typedef struct {
    int          addr;
    logic [15:0] data;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[7];

  reg_readback #(
    .NUM_REGS     (NR),
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .reg_bank  (reg_bank),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Frame as a list of transmitted bits; bit k of the result is the k-th bit on tx.
  function automatic logic [22:0] model_frame(input int a, input logic [15:0] d);
    bit q[$];
    int ones;
    logic [22:0] f;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < AW; i++) q.push_back(a[i]);
    for (int i = 0; i < DW; i++) q.push_back(d[i]);
    for (int i = 0; i < q.size(); i++) if (q[i]) ones++;
    q.push_back((ones % 2) == 1);
    q.push_back(1'b1);
    for (int i = 0; i < FB; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic randomize_bank();
    for (int r = 0; r < NR; r++) reg_bank[r*DW +: DW] = 16'($urandom);
  endtask

  // Present a request at a falling edge and return at the falling edge of cycle 1.
  task automatic start_req(input int a, input string nm);
    req_addr  = 4'(a);
    req_valid = 1'b1;
    chk({nm, " ready_before"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_frame(input logic [22:0] exp, input string nm,
                             input bit mutate, input bit busy_req, input bit keep_valid);
    logic [22:0] got;
    int hold_bad;
    int busy_bad;
    got = 23'd0;
    hold_bad = 0;
    busy_bad = 0;
    for (int cyc = 1; cyc <= FCYC; cyc++) begin
      int k;
      k = (cyc - 1) / CPB;
      if (((cyc - 1) % CPB) == 0) got[k] = tx;
      else if (tx !== got[k]) hold_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (cyc == 1 && !keep_valid) req_valid = 1'b0;
      if (mutate && cyc == 2) reg_bank = {NR*DW{1'b1}};
      if (busy_req && cyc == 10) begin
        req_addr  = 4'd2;
        req_valid = 1'b1;
        chk({nm, " ready_while_busy"}, {31'd0, req_ready}, 32'd0);
      end
      if (busy_req && cyc == 80) req_valid = 1'b0;
      @(negedge clk);
    end
    chk({nm, " frame"}, {9'd0, got}, {9'd0, exp});
    chk({nm, " bit_hold"}, hold_bad, 32'd0);
    chk({nm, " busy_during"}, busy_bad, 32'd0);
    chk({nm, " done_pulse"}, {31'd0, done}, 32'd1);
    chk({nm, " ready_at_done"}, {31'd0, req_ready}, 32'd1);
    chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({nm, " tx_idle"}, {31'd0, tx}, 32'd1);
    if (!keep_valid) begin
      @(negedge clk);
      chk({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    int d0;
    int inv[3];
    logic [15:0] dv;
    clk = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = 4'd0;
    reg_bank = {NR*DW{1'b0}};
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;

    tbl[0] = '{3,  16'hA5C3, {1'b1, 1'b0, 16'hA5C3, 4'h3, 1'b0}};
    tbl[1] = '{0,  16'h0000, {1'b1, 1'b0, 16'h0000, 4'h0, 1'b0}};
    tbl[2] = '{11, 16'hFFFF, {1'b1, 1'b1, 16'hFFFF, 4'hB, 1'b0}};
    for (int i = 3; i < 7; i++) begin
      tbl[i].addr = $urandom_range(0, NR - 1);
      tbl[i].data = 16'($urandom);
      tbl[i].exp  = model_frame(tbl[i].addr, tbl[i].data);
    end

    @(negedge clk);
    @(negedge clk);
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst ready", {31'd0, req_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst addr_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      randomize_bank();
      reg_bank[tbl[i].addr*DW +: DW] = tbl[i].data;
      start_req(tbl[i].addr, $sformatf("vec%0d", i));
      check_frame(tbl[i].exp, $sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Rejected addresses at and beyond NUM_REGS
    inv[0] = 12; inv[1] = 13; inv[2] = 15;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      req_addr = 4'(inv[i]);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("inv%0d addr_err", inv[i]), {31'd0, addr_err}, 32'd1);
      chk($sformatf("inv%0d ready", inv[i]), {31'd0, req_ready}, 32'd1);
      chk($sformatf("inv%0d tx", inv[i]), {31'd0, tx}, 32'd1);
      chk($sformatf("inv%0d busy", inv[i]), {31'd0, busy}, 32'd0);
      chk($sformatf("inv%0d done", inv[i]), {31'd0, done}, 32'd0);
      @(negedge clk);
      chk($sformatf("inv%0d addr_err_clear", inv[i]), {31'd0, addr_err}, 32'd0);
    end
    repeat (4) @(negedge clk);
    chk("inv no_done", done_cnt, d0);

    // Snapshot must survive a bank change two cycles after acceptance
    randomize_bank();
    reg_bank[5*DW +: DW] = 16'h0001;
    start_req(5, "stale");
    check_frame({1'b1, 1'b1, 16'h0001, 4'h5, 1'b0}, "stale", 1'b1, 1'b0, 1'b0);

    // Request while busy is ignored and the frame is unaffected
    randomize_bank();
    dv = 16'($urandom);
    reg_bank[7*DW +: DW] = dv;
    start_req(7, "busyreq");
    check_frame(model_frame(7, dv), "busyreq", 1'b0, 1'b1, 1'b0);
    chk("busyreq no_accept_after", {31'd0, busy}, 32'd0);

    // Back-to-back frames with req_valid held
    randomize_bank();
    d0 = done_cnt;
    start_req(0, "b2b0");
    req_addr = 4'd1;
    check_frame(model_frame(0, reg_bank[0 +: DW]), "b2b0", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_frame(model_frame(1, reg_bank[DW +: DW]), "b2b1", 1'b0, 1'b0, 1'b0);
    chk("b2b done_count", done_cnt - d0, 32'd2);

    // Reset during DATA bit 7 aborts the frame asynchronously
    randomize_bank();
    start_req(3, "rstmid");
    req_valid = 1'b0;
    repeat (49) @(negedge clk);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid tx", {31'd0, tx}, 32'd1);
    chk("rstmid busy", {31'd0, busy}, 32'd0);
    chk("rstmid ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rstmid no_done", done_cnt, d0);
    chk("rstmid tx_idle", {31'd0, tx}, 32'd1);
    dv = 16'($urandom);
    reg_bank[4*DW +: DW] = dv;
    start_req(4, "rstfresh");
    check_frame(model_frame(4, dv), "rstfresh", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
